// File: rtl/sys_cmd_master.sv
// ============================================================================
// sys_cmd_master
// ----------------------------------------------------------------------------
// Host-side command initiator for the system-control byte protocol.
// A single parallel request (write, read, ALU with operands, ALU without
// operands) is accepted, serialised into command frames on the UART TX byte
// interface, and for every command except write the one-byte response coming
// back on the UART RX byte interface is captured and returned to the host.
//
// Frames (first byte is the command byte):
//   write             : AA, addr, data_a           (no response)
//   read              : BB, addr                   (one response byte)
//   ALU with operands : CC, data_a, data_b, fun    (one response byte)
//   ALU w/o operands  : DD, fun                    (one response byte)
//
// Parameters:
//   Data_width      byte width of frame and response data
//   Address_width   register-file address width, zero-extended into a byte
//   Gap_cycles      idle cycles after every transmitted byte, legal 1..255
//   Timeout_cycles  response wait limit, only used with RSP_TIMEOUT_EN
//
// Ports:
//   CLK, RST        clock and asynchronous active-high reset
//   REQ_valid       request present
//   REQ_ready       request can be accepted (high only in IDLE)
//   REQ_cmd         00 write, 01 read, 10 ALU with operands, 11 ALU w/o ops
//   REQ_addr        register address for write/read
//   REQ_data_a      write data or ALU operand A
//   REQ_data_b      ALU operand B
//   REQ_fun         ALU function, zero-extended into the function byte
//   TX_p_data       frame byte to UART TX (holds last sent byte)
//   TX_d_valid      one-cycle byte strobe
//   TX_busy         UART TX cannot take a byte
//   RX_p_data       response byte from UART RX
//   RX_d_valid      one-cycle response strobe
//   RSP_data        captured response byte
//   RSP_valid       one-cycle response-complete pulse
//   RSP_timeout     one-cycle timeout pulse (tied low without RSP_TIMEOUT_EN)
//   busy            high whenever the FSM is not in IDLE
//
// Configuration macro:
//   RSP_TIMEOUT_EN  when defined, WAIT_RSP gives up after Timeout_cycles
//                   cycles without a response and pulses RSP_timeout.
// ============================================================================
module sys_cmd_master #(
    parameter int Data_width     = 8,
    parameter int Address_width  = 4,
    parameter int Gap_cycles     = 2,
    parameter int Timeout_cycles = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_valid,
    output logic                     REQ_ready,
    input  logic [1:0]               REQ_cmd,
    input  logic [Address_width-1:0] REQ_addr,
    input  logic [Data_width-1:0]    REQ_data_a,
    input  logic [Data_width-1:0]    REQ_data_b,
    input  logic [3:0]               REQ_fun,
    output logic [Data_width-1:0]    TX_p_data,
    output logic                     TX_d_valid,
    input  logic                     TX_busy,
    input  logic [Data_width-1:0]    RX_p_data,
    input  logic                     RX_d_valid,
    output logic [Data_width-1:0]    RSP_data,
    output logic                     RSP_valid,
    output logic                     RSP_timeout,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        GAP,
        WAIT_RSP,
        DONE
    } state_t;

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_ALU   = 2'b10;
    localparam logic [1:0] CMD_ALUNO = 2'b11;

    localparam logic [Data_width-1:0] BYTE_WRITE = Data_width'(8'hAA);
    localparam logic [Data_width-1:0] BYTE_READ  = Data_width'(8'hBB);
    localparam logic [Data_width-1:0] BYTE_ALU   = Data_width'(8'hCC);
    localparam logic [Data_width-1:0] BYTE_ALUNO = Data_width'(8'hDD);

    // Terminal value of the 8-bit gap counter; it counts 0..Gap_cycles-1.
    localparam logic [7:0] GAP_LAST = 8'(Gap_cycles - 1);

    state_t                   r_state;
    state_t                   w_nextState;

    logic [1:0]               r_cmd;
    logic [Address_width-1:0] r_addr;
    logic [Data_width-1:0]    r_dataA;
    logic [Data_width-1:0]    r_dataB;
    logic [3:0]               r_fun;

    logic [1:0]               r_byteIdx;
    logic [7:0]               r_gapCnt;
    logic [Data_width-1:0]    r_txHold;
    logic [Data_width-1:0]    r_rspData;

    logic                     w_accept;
    logic                     w_txStrobe;
    logic                     w_gapDone;
    logic                     w_allSent;
    logic                     w_toExpire;
    logic [1:0]               w_endIdx;
    logic [Data_width-1:0]    w_curByte;

`ifdef RSP_TIMEOUT_EN
    localparam int TO_W = (Timeout_cycles > 1) ? $clog2(Timeout_cycles) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(Timeout_cycles - 1);

    logic [TO_W-1:0]          r_toCnt;
`endif

    // Frame byte selection. The byte index points at the byte that goes out
    // on the next strobe; unused slots of the shorter frames read as zero.
    // The end index is the value the byte index reaches once the final byte
    // has been strobed; for the 4-byte ALU frame the 2-bit index wraps to 0.
    always_comb begin
        w_curByte = '0;
        w_endIdx  = 2'd0;
        case (r_cmd)
            CMD_WRITE: begin
                w_endIdx = 2'd3;
                case (r_byteIdx)
                    2'd0:    w_curByte = BYTE_WRITE;
                    2'd1:    w_curByte = Data_width'(r_addr);
                    2'd2:    w_curByte = r_dataA;
                    default: w_curByte = '0;
                endcase
            end
            CMD_READ: begin
                w_endIdx = 2'd2;
                case (r_byteIdx)
                    2'd0:    w_curByte = BYTE_READ;
                    2'd1:    w_curByte = Data_width'(r_addr);
                    default: w_curByte = '0;
                endcase
            end
            CMD_ALU: begin
                w_endIdx = 2'd0;
                case (r_byteIdx)
                    2'd0:    w_curByte = BYTE_ALU;
                    2'd1:    w_curByte = r_dataA;
                    2'd2:    w_curByte = r_dataB;
                    default: w_curByte = Data_width'(r_fun);
                endcase
            end
            default: begin
                w_endIdx = 2'd2;
                case (r_byteIdx)
                    2'd0:    w_curByte = BYTE_ALUNO;
                    2'd1:    w_curByte = Data_width'(r_fun);
                    default: w_curByte = '0;
                endcase
            end
        endcase
    end

    // Helper conditions shared by the FSM and the datapath. The response
    // timeout only exists when the timeout feature is compiled in.
    always_comb begin
        w_accept   = REQ_valid && (r_state == IDLE);
        w_gapDone  = (r_gapCnt == GAP_LAST);
        w_allSent  = (r_byteIdx == w_endIdx);
`ifdef RSP_TIMEOUT_EN
        w_toExpire = (r_toCnt == TO_LAST);
`else
        w_toExpire = 1'b0;
`endif
    end

    // State register. Reset aborts any frame in flight straight back to IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode. The byte strobe is combinational so that
    // a byte leaves in the very first SEND cycle after acceptance. A response
    // arriving in the same cycle the timeout expires is taken as a response.
    always_comb begin
        w_nextState = r_state;
        w_txStrobe  = 1'b0;
        REQ_ready   = 1'b0;
        busy        = 1'b1;
        RSP_valid   = 1'b0;
        RSP_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                REQ_ready = 1'b1;
                busy      = 1'b0;
                if (w_accept) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                if (!TX_busy) begin
                    w_txStrobe  = 1'b1;
                    w_nextState = GAP;
                end
            end
            GAP: begin
                if (w_gapDone) begin
                    if (!w_allSent) begin
                        w_nextState = SEND;
                    end else if (r_cmd == CMD_WRITE) begin
                        w_nextState = IDLE;
                    end else begin
                        w_nextState = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (RX_d_valid) begin
                    w_nextState = DONE;
                end else if (w_toExpire) begin
                    RSP_timeout = 1'b1;
                    w_nextState = IDLE;
                end
            end
            DONE: begin
                RSP_valid   = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request capture, byte sequencing and response capture. All request
    // fields are frozen at acceptance so the host may change its inputs
    // freely while the frame is in flight. The gap counter restarts on each
    // strobe and counts up during GAP until its terminal value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cmd     <= CMD_WRITE;
            r_addr    <= '0;
            r_dataA   <= '0;
            r_dataB   <= '0;
            r_fun     <= '0;
            r_byteIdx <= 2'd0;
            r_gapCnt  <= 8'd0;
            r_txHold  <= '0;
            r_rspData <= '0;
        end else begin
            if (w_accept) begin
                r_cmd     <= REQ_cmd;
                r_addr    <= REQ_addr;
                r_dataA   <= REQ_data_a;
                r_dataB   <= REQ_data_b;
                r_fun     <= REQ_fun;
                r_byteIdx <= 2'd0;
            end
            if (w_txStrobe) begin
                r_txHold  <= w_curByte;
                r_byteIdx <= r_byteIdx + 2'd1;
                r_gapCnt  <= 8'd0;
            end else if ((r_state == GAP) && !w_gapDone) begin
                r_gapCnt  <= r_gapCnt + 8'd1;
            end
            if ((r_state == WAIT_RSP) && RX_d_valid) begin
                r_rspData <= RX_p_data;
            end
        end
    end

`ifdef RSP_TIMEOUT_EN
    // Response wait counter: held at zero outside WAIT_RSP, so every wait
    // starts from zero and the FSM leaves WAIT_RSP before it could wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_toCnt <= '0;
        end else if (r_state != WAIT_RSP) begin
            r_toCnt <= '0;
        end else begin
            r_toCnt <= r_toCnt + 1'b1;
        end
    end
`endif

    // The data bus shows the byte being strobed and otherwise holds the last
    // byte that actually left, so a stalled SEND never previews a new byte.
    assign TX_p_data  = w_txStrobe ? w_curByte : r_txHold;
    assign TX_d_valid = w_txStrobe;
    assign RSP_data   = r_rspData;

endmodule

// File: tb/tb_sys_cmd_master.sv
// ============================================================================
// tb_sys_cmd_master
// ----------------------------------------------------------------------------
// Directed, self-checking bench for sys_cmd_master. Expected frame bytes are
// queued when a request is driven and checked as strobes appear; expected
// response bytes are queued when the RX side is driven and checked when
// RSP_valid appears. Timeout cases are built only with RSP_TIMEOUT_EN.
// ============================================================================
module tb_sys_cmd_master;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int GAP = 2;
    localparam int TO  = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_valid = 1'b0;
    logic          REQ_ready;
    logic [1:0]    REQ_cmd = 2'b00;
    logic [AW-1:0] REQ_addr = '0;
    logic [DW-1:0] REQ_data_a = '0;
    logic [DW-1:0] REQ_data_b = '0;
    logic [3:0]    REQ_fun = '0;
    logic [DW-1:0] TX_p_data;
    logic          TX_d_valid;
    logic          TX_busy = 1'b0;
    logic [DW-1:0] RX_p_data = '0;
    logic          RX_d_valid = 1'b0;
    logic [DW-1:0] RSP_data;
    logic          RSP_valid;
    logic          RSP_timeout;
    logic          busy;

    sys_cmd_master #(
        .Data_width    (DW),
        .Address_width (AW),
        .Gap_cycles    (GAP),
        .Timeout_cycles(TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ_valid  (REQ_valid),
        .REQ_ready  (REQ_ready),
        .REQ_cmd    (REQ_cmd),
        .REQ_addr   (REQ_addr),
        .REQ_data_a (REQ_data_a),
        .REQ_data_b (REQ_data_b),
        .REQ_fun    (REQ_fun),
        .TX_p_data  (TX_p_data),
        .TX_d_valid (TX_d_valid),
        .TX_busy    (TX_busy),
        .RX_p_data  (RX_p_data),
        .RX_d_valid (RX_d_valid),
        .RSP_data   (RSP_data),
        .RSP_valid  (RSP_valid),
        .RSP_timeout(RSP_timeout),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int          nAssert = 0;
    int          nFail   = 0;
    int          cyc     = 0;
    int          accCyc  = 0;
    int          rspCyc  = 0;
    int          toCyc   = 0;
    int          rspSeen = 0;
    int          toSeen  = 0;
    int          readyCyc = 0;
    logic        sReady  = 1'b0;
    logic        sBusy   = 1'b0;
    logic [7:0]  expTx[$];
    logic [7:0]  expRsp[$];
    int          txCyc[$];

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Outputs are sampled at the falling edge, which shows
    // exactly what the next rising edge will act on; inputs change 1 time
    // unit after the rising edge when the task returns.
    task automatic tick();
        logic [31:0] e;
        @(negedge CLK);
        cyc++;
        sReady = REQ_ready;
        sBusy  = busy;
        if (TX_d_valid) begin
            if (expTx.size() > 0) e = {24'd0, expTx.pop_front()};
            else                  e = 32'hFFFF_FFFF;
            checkOutput("tx_byte", {24'd0, TX_p_data}, e);
            txCyc.push_back(cyc);
        end
        if (RSP_valid) begin
            if (expRsp.size() > 0) e = {24'd0, expRsp.pop_front()};
            else                   e = 32'hFFFF_FFFF;
            checkOutput("rsp_data", {24'd0, RSP_data}, e);
            rspCyc = cyc;
            rspSeen++;
        end
        if (RSP_timeout) begin
            toCyc = cyc;
            toSeen++;
        end
        @(posedge CLK);
        #1;
    endtask

    // Present one request for one cycle, queue its expected frame, then
    // scramble the request inputs to show that only the accepted copy counts.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [3:0] addr,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] fun);
        REQ_cmd    = cmd;
        REQ_addr   = addr;
        REQ_data_a = a;
        REQ_data_b = b;
        REQ_fun    = fun;
        REQ_valid  = 1'b1;
        case (cmd)
            2'b00: begin expTx.push_back(8'hAA); expTx.push_back({4'h0, addr}); expTx.push_back(a); end
            2'b01: begin expTx.push_back(8'hBB); expTx.push_back({4'h0, addr}); end
            2'b10: begin expTx.push_back(8'hCC); expTx.push_back(a); expTx.push_back(b); expTx.push_back({4'h0, fun}); end
            default: begin expTx.push_back(8'hDD); expTx.push_back({4'h0, fun}); end
        endcase
        txCyc.delete();
        checkOutput("ready_at_accept", {31'd0, REQ_ready}, 32'd1);
        tick();
        accCyc     = cyc;
        REQ_valid  = 1'b0;
        REQ_cmd    = ~cmd;
        REQ_addr   = ~addr;
        REQ_data_a = ~a;
        REQ_data_b = ~b;
        REQ_fun    = ~fun;
    endtask

    task automatic waitTx(input int n, input int bound);
        int k = 0;
        while (txCyc.size() < n && k < bound) begin
            tick();
            k++;
        end
        checkOutput("tx_count", txCyc.size(), n);
    endtask

    task automatic waitReady(input int bound);
        int k = 0;
        tick();
        while (!sReady && k < bound) begin
            tick();
            k++;
        end
        checkOutput("ready_return", {31'd0, sReady}, 32'd1);
        readyCyc = cyc;
    endtask

    task automatic sendRsp(input logic [7:0] d);
        RX_p_data  = d;
        RX_d_valid = 1'b1;
        expRsp.push_back(d);
        tick();
        RX_d_valid = 1'b0;
        RX_p_data  = 8'h00;
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        RST = 1'b0;
        tick();
        checkOutput("rst_ready",  {31'd0, REQ_ready},   32'd1);
        checkOutput("rst_busy",   {31'd0, busy},        32'd0);
        checkOutput("rst_txv",    {31'd0, TX_d_valid},  32'd0);
        checkOutput("rst_txdata", {24'd0, TX_p_data},   32'd0);
        checkOutput("rst_rspdat", {24'd0, RSP_data},    32'd0);
        checkOutput("rst_rspv",   {31'd0, RSP_valid},   32'd0);
        checkOutput("rst_rspto",  {31'd0, RSP_timeout}, 32'd0);

        // Write: AA,05,AB, no response
        $display("[TB] write request");
        applyStimulus(2'b00, 4'h5, 8'hAB, 8'h00, 4'h0);
        tick();
        checkOutput("wr_ready_drop", {31'd0, sReady}, 32'd0);
        checkOutput("wr_busy_high",  {31'd0, sBusy},  32'd1);
        waitTx(3, 40);
        checkOutput("wr_first_lat", txCyc[0] - accCyc, 1);
        checkOutput("wr_space1",    txCyc[1] - txCyc[0], GAP + 1);
        checkOutput("wr_space2",    txCyc[2] - txCyc[1], GAP + 1);
        waitReady(20);
        checkOutput("wr_ready_lat", readyCyc - txCyc[2], GAP + 1);
        checkOutput("wr_no_rsp", rspSeen, 0);

        // Read: BB,05, response AB in the first WAIT_RSP cycle
        $display("[TB] read request");
        applyStimulus(2'b01, 4'h5, 8'h00, 8'h00, 4'h0);
        waitTx(2, 40);
        checkOutput("rd_space", txCyc[1] - txCyc[0], GAP + 1);
        repeat (GAP) tick();
        sendRsp(8'hAB);
        checkOutput("rd_rsp_cnt", rspSeen, 1);
        checkOutput("rd_rsp_lat", rspCyc - txCyc[1], GAP + 2);
        checkOutput("rd_rsp_hold", {24'd0, RSP_data}, 32'hAB);
        tick();
        checkOutput("rd_ready", {31'd0, sReady}, 32'd1);

        // ALU with operands, TX_busy stall of 5 cycles before byte 2
        $display("[TB] ALU request with stall");
        applyStimulus(2'b10, 4'h0, 8'h10, 8'h25, 4'h0);
        waitTx(1, 10);
        TX_busy = 1'b1;
        repeat (5) tick();
        TX_busy = 1'b0;
        waitTx(4, 60);
        checkOutput("alu_stall_space", txCyc[1] - txCyc[0], 6);
        checkOutput("alu_space2",      txCyc[2] - txCyc[1], GAP + 1);
        checkOutput("alu_space3",      txCyc[3] - txCyc[2], GAP + 1);
        repeat (5) tick();
        sendRsp(8'h35);
        checkOutput("alu_rsp_cnt", rspSeen, 2);
        checkOutput("alu_rsp_data", {24'd0, RSP_data}, 32'h35);
        tick();

        // Stray RX in IDLE, then ALU without operands
        $display("[TB] stray response then ALU without operands");
        RX_p_data  = 8'h77;
        RX_d_valid = 1'b1;
        tick();
        RX_d_valid = 1'b0;
        RX_p_data  = 8'h00;
        tick();
        checkOutput("stray_hold",   {24'd0, RSP_data}, 32'h35);
        checkOutput("stray_no_rsp", rspSeen, 2);
        applyStimulus(2'b11, 4'h0, 8'h00, 8'h00, 4'h1);
        waitTx(2, 40);
        checkOutput("alun_space", txCyc[1] - txCyc[0], GAP + 1);
        repeat (GAP + 1) tick();
        sendRsp(8'h54);
        checkOutput("alun_rsp_cnt", rspSeen, 3);
        checkOutput("alun_rsp_lat", rspCyc - txCyc[1], GAP + 3);
        checkOutput("alun_rsp_data", {24'd0, RSP_data}, 32'h54);
        tick();

`ifdef RSP_TIMEOUT_EN
        // Read with no response: timeout in the 8th WAIT_RSP cycle
        $display("[TB] response timeout");
        applyStimulus(2'b01, 4'h2, 8'h00, 8'h00, 4'h0);
        waitTx(2, 40);
        begin
            int k = 0;
            while (toSeen == 0 && k < 40) begin
                tick();
                k++;
            end
        end
        checkOutput("to_count", toSeen, 1);
        checkOutput("to_lat", toCyc - txCyc[1], GAP + TO);
        checkOutput("to_rsp_hold", {24'd0, RSP_data}, 32'h54);
        checkOutput("to_no_rsp", rspSeen, 3);
        tick();
        checkOutput("to_ready", {31'd0, sReady}, 32'd1);

        // Response in the same cycle the wait expires wins
        $display("[TB] response at timeout boundary");
        applyStimulus(2'b01, 4'h3, 8'h00, 8'h00, 4'h0);
        waitTx(2, 40);
        repeat (GAP + TO - 1) tick();
        sendRsp(8'h99);
        checkOutput("race_rsp_cnt", rspSeen, 4);
        checkOutput("race_no_to", toSeen, 1);
        checkOutput("race_rsp_data", {24'd0, RSP_data}, 32'h99);
        tick();
`else
        checkOutput("no_timeout", toSeen, 0);
`endif

        // Reset mid-frame after byte CC, then a clean write
        $display("[TB] reset mid-frame");
        applyStimulus(2'b10, 4'h0, 8'h11, 8'h22, 4'h3);
        waitTx(1, 10);
        expTx.delete();
        RST = 1'b1;
        #2;
        checkOutput("mid_rst_txv",   {31'd0, TX_d_valid},  32'd0);
        checkOutput("mid_rst_busy",  {31'd0, busy},        32'd0);
        checkOutput("mid_rst_ready", {31'd0, REQ_ready},   32'd1);
        checkOutput("mid_rst_txd",   {24'd0, TX_p_data},   32'd0);
        checkOutput("mid_rst_rspd",  {24'd0, RSP_data},    32'd0);
        checkOutput("mid_rst_rspv",  {31'd0, RSP_valid},   32'd0);
        checkOutput("mid_rst_rspto", {31'd0, RSP_timeout}, 32'd0);
        repeat (3) tick();
        RST = 1'b0;
        repeat (12) tick();
        checkOutput("mid_rst_no_tx", txCyc.size(), 1);
        applyStimulus(2'b00, 4'h3, 8'h5A, 8'h00, 4'h0);
        waitTx(3, 40);
        checkOutput("post_rst_lat",   txCyc[0] - accCyc, 1);
        checkOutput("post_rst_space", txCyc[2] - txCyc[0], 2 * (GAP + 1));
        waitReady(20);

        checkOutput("exp_tx_empty",  expTx.size(), 0);
        checkOutput("exp_rsp_empty", expRsp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed time %0t, expected end before 100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sys_cmd_master.md
# sys_cmd_master

- Host-side command initiator for the system-control byte protocol.
- Accepts one parallel request at a time (write, read, ALU with operands, ALU without operands).
- Serialises the request into the UART TX byte stream as command frames, then waits for and returns the one-byte response from the response stream.
- Sits between a host/test sequencer and the UART TX/RX byte interfaces that face the system controller.

## Interface
Parameters:
- Data_width, 8, byte width of frame and response data
- Address_width, 4, register-file address width; zero-extended into the address byte
- Gap_cycles, 2, idle cycles enforced after each transmitted byte (legal 1..255)
- Timeout_cycles, 64, response wait limit in cycles (only with RSP_TIMEOUT_EN)

Ports:
- CLK  in  1  clock; one clock for the whole block
- RST  in  1  asynchronous, active-high reset
- REQ_valid  in  1  request present
- REQ_ready  out  1  block can accept a request; high only in IDLE
- REQ_cmd  in  2  00 write, 01 read, 10 ALU with operands, 11 ALU without operands
- REQ_addr  in  Address_width  register address (write/read)
- REQ_data_a  in  Data_width  write data, or ALU operand A
- REQ_data_b  in  Data_width  ALU operand B
- REQ_fun  in  4  ALU function; zero-extended into the function byte
- TX_p_data  out  Data_width  frame byte to UART TX
- TX_d_valid  out  1  one-cycle byte strobe
- TX_busy  in  1  UART TX cannot take a byte
- RX_p_data  in  Data_width  response byte from UART RX
- RX_d_valid  in  1  one-cycle response strobe
- RSP_data  out  Data_width  captured response byte
- RSP_valid  out  1  one-cycle response-complete pulse
- RSP_timeout  out  1  one-cycle timeout pulse
- busy  out  1  high whenever the state is not IDLE

## Operation
- Frames (first byte is the command):
  - write: AA, addr, data_a (3 bytes, no response)
  - read: BB, addr (2 bytes, one response)
  - ALU with operands: CC, data_a, data_b, fun (4 bytes, one response)
  - ALU without operands: DD, fun (2 bytes, one response)
- Accept on REQ_valid & REQ_ready. All request fields are registered at acceptance; later input changes are ignored.
- FSM states: IDLE, SEND, GAP, WAIT_RSP, DONE.
  - IDLE -> SEND on accept.
  - SEND: when TX_busy=0, drive the current byte with TX_d_valid=1 for one cycle, advance the byte index, go to GAP. While TX_busy=1, stay in SEND with TX_d_valid=0.
  - GAP: count Gap_cycles. At the end:
    - more bytes to send -> SEND
    - last byte sent, write -> IDLE
    - last byte sent, other commands -> WAIT_RSP
  - WAIT_RSP: on RX_d_valid, capture RX_p_data into RSP_data and go to DONE.
  - DONE: RSP_valid=1 for one cycle, then IDLE.
- RX_d_valid outside WAIT_RSP is ignored; RSP_data holds its last value.
- Byte index is 2 bits (max 4 bytes) and is cleared on accept.
- The gap counter is 8 bits. A Gap_cycles value outside 1..255 is illegal.

## Timing
- Reset values (async, while RST=1): state IDLE; REQ_ready=1 after reset release; all other outputs 0; TX_p_data=0; RSP_data=0; counters 0.
- TX_p_data holds the last sent byte between strobes.
- Accept in cycle N; first TX_d_valid at N+1 at the earliest (TX_busy=0).
- Byte-to-byte spacing is Gap_cycles+1 cycles minimum, plus any TX_busy stall.
- REQ_ready drops the cycle after accept and returns the cycle after DONE (or after the final GAP for a write).
- RX_d_valid arriving in the first WAIT_RSP cycle is captured. Response latency is 1 cycle from RX_d_valid to RSP_valid.
- RST asserted mid-frame aborts immediately: no further TX_d_valid, and no RSP_valid or RSP_timeout for the aborted request.

## Configuration
- RSP_TIMEOUT_EN defined:
  - WAIT_RSP counts cycles.
  - After Timeout_cycles cycles without RX_d_valid, RSP_timeout pulses for one cycle and the FSM returns to IDLE. RSP_data is unchanged.
  - If RX_d_valid arrives in the same cycle the count expires, the response wins: RSP_valid, no timeout.
- RSP_TIMEOUT_EN undefined:
  - WAIT_RSP waits indefinitely.
  - RSP_timeout is tied to 0 and no timeout counter is built.

## Test plan
- Write: cmd=00, addr=5, data_a=AB, TX_busy=0 -> bytes AA,05,AB, each strobe 3 cycles apart (Gap_cycles=2); no RSP_valid; REQ_ready high 3 cycles after the last strobe.
- Read: cmd=01, addr=5, then RX byte AB in WAIT_RSP -> bytes BB,05; RSP_valid one cycle later with RSP_data=AB.
- ALU with operands: cmd=10, A=10, B=25, fun=0, TX_busy held high 5 cycles before byte 2 -> bytes CC,10,25,00 with the second byte delayed by the stall; response 35 -> RSP_data=35.
- ALU without operands: cmd=11, fun=1 -> bytes DD,01; response 54 -> RSP_valid with 54. A stray RX_d_valid while in IDLE beforehand leaves RSP_data unchanged.
- Timeout (RSP_TIMEOUT_EN, Timeout_cycles=8): read with no response -> RSP_timeout pulse 8 cycles into WAIT_RSP, then REQ_ready=1.
- Reset mid-frame: assert RST after byte CC of an ALU request -> TX_d_valid=0 immediately, all outputs at reset values; a new write request after release sends a full AA frame.
